// File: rtl/mul_hilo_pkg.sv
// Shared funct codes and FSM state encoding for the HI/LO multiply unit.
package mul_hilo_pkg;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_hilo_unit_if.sv
// Execute-stage bus between the pipeline (master) and the HI/LO multiply unit (slave).
interface mul_hilo_unit_if #(parameter int WIDTH = 32);

  logic             valid;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] aluOut;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;

  modport master (
    output valid, Signal, dataA, dataB, aluOut,
    input  dataOut, busy, done
  );

  modport slave (
    input  valid, Signal, dataA, dataB, aluOut,
    output dataOut, busy, done
  );

endinterface

// File: rtl/mul_shift_add.sv
// Shift-add multiplier datapath: multiplicand, multiplier and product registers plus the adder.
module mul_shift_add #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] product_next
);

  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] product_r;

  assign product_next = product_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

  // Load operands on acceptance, then one add/shift per multiply cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
    end else if (load) begin
      mcand_r   <= {{WIDTH{1'b0}}, mcand_in};
      mplier_r  <= mplier_in;
      product_r <= {(2*WIDTH){1'b0}};
    end else if (step) begin
      product_r <= product_next;
      mcand_r   <= mcand_r << 1;
      mplier_r  <= mplier_r >> 1;
    end else begin
      product_r <= product_r;
      mcand_r   <= mcand_r;
      mplier_r  <= mplier_r;
    end
  end

endmodule

// File: rtl/mul_hilo_unit.sv
// Multi-cycle MULTU unit with HI/LO registers and MFHI/MFLO result mux.
// Define SIGNED_MULT_EN to also accept MULT (sign-magnitude multiply, negate at commit).
module mul_hilo_unit
  import mul_hilo_pkg::*;
#(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            reset,
  mul_hilo_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               is_mul_s;
  logic               start_s;
  logic               step_s;
  logic               last_s;
  logic [WIDTH-1:0]   mcand_s;
  logic [WIDTH-1:0]   mplier_s;
  logic [2*WIDTH-1:0] prod_next_s;
  logic [2*WIDTH-1:0] result_s;

`ifdef SIGNED_MULT_EN
  logic is_signed_s;
  logic neg_r;

  assign is_signed_s = (bus.Signal == MULT);
  assign is_mul_s    = bus.valid && ((bus.Signal == MULTU) || is_signed_s);
  // Signed operands are reduced to magnitudes; the sign is reapplied at commit.
  assign mcand_s     = (is_signed_s && bus.dataA[WIDTH-1]) ? (-bus.dataA) : bus.dataA;
  assign mplier_s    = (is_signed_s && bus.dataB[WIDTH-1]) ? (-bus.dataB) : bus.dataB;
  assign result_s    = neg_r ? (-prod_next_s) : prod_next_s;

  // Remember whether the committed product must be negated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_r <= 1'b0;
    end else if (start_s) begin
      neg_r <= is_signed_s && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
    end else begin
      neg_r <= neg_r;
    end
  end
`else
  assign is_mul_s = bus.valid && (bus.Signal == MULTU);
  assign mcand_s  = bus.dataA;
  assign mplier_s = bus.dataB;
  assign result_s = prod_next_s;
`endif

  assign start_s = (state_r == IDLE) && is_mul_s;
  assign step_s  = (state_r == MUL);
  assign last_s  = (cnt_r == CNT_W'(WIDTH - 1));

  mul_shift_add #(.WIDTH(WIDTH)) u_core (
    .clk          (clk),
    .reset        (reset),
    .load         (start_s),
    .step         (step_s),
    .mcand_in     (mcand_s),
    .mplier_in    (mplier_s),
    .product_next (prod_next_s)
  );

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start_s ? MUL : IDLE;
      MUL:     state_next_s = last_s ? DONE : MUL;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == MUL);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Iteration counter and HI/LO commit on the final multiply cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
    end else if (start_s) begin
      cnt_r <= {CNT_W{1'b0}};
      hi_r  <= hi_r;
      lo_r  <= lo_r;
    end else if (step_s) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
      if (last_s) begin
        hi_r <= result_s[2*WIDTH-1:WIDTH];
        lo_r <= result_s[WIDTH-1:0];
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end else begin
      cnt_r <= cnt_r;
      hi_r  <= hi_r;
      lo_r  <= lo_r;
    end
  end

  // Result mux stays combinational so aluOut passes through even in reset.
  always_comb begin
    bus.dataOut = bus.aluOut;
    if (bus.valid && (bus.Signal == MFHI)) begin
      bus.dataOut = hi_r;
    end else if (bus.valid && (bus.Signal == MFLO)) begin
      bus.dataOut = lo_r;
    end else begin
      bus.dataOut = bus.aluOut;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Randomized scoreboard bench for mul_hilo_unit against a cycle-indexed arithmetic model.
module tb_mul_hilo_unit;
  import mul_hilo_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        busy;
    logic        done;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  // Reference model: one pending operation described by its acceptance edge.
  int          cyc;
  bit          op_active;
  bit          op_committed;
  int          op_edge;
  logic [63:0] op_prod;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mul_hilo_unit_if #(.WIDTH(32)) bus ();

  mul_hilo_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_mul_funct(input logic [5:0] sig);
`ifdef SIGNED_MULT_EN
    return (sig == MULTU) || (sig == MULT);
`else
    return (sig == MULTU);
`endif
  endfunction

  function automatic logic [63:0] ref_product(input logic [5:0] sig, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sig == MULTU) begin
      return {32'h0, a} * {32'h0, b};
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
  endfunction

  task automatic step(input bit rst, input bit v, input logic [5:0] sig,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu);
    exp_t e;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    reset = rst;
    bus.valid = v;
    bus.Signal = sig;
    bus.dataA = a;
    bus.dataB = b;
    bus.aluOut = alu;
    if (rst) begin
      op_active = 1'b0;
      hi_m = 32'h0;
      lo_m = 32'h0;
    end else if (op_active && !op_committed && cyc >= op_edge + 32) begin
      hi_m = op_prod[63:32];
      lo_m = op_prod[31:0];
      op_committed = 1'b1;
    end
    if (op_active && cyc > op_edge + 32) op_active = 1'b0;
    e.busy = op_active && cyc >= op_edge && cyc <= op_edge + 31;
    e.done = op_active && cyc == op_edge + 32;
    e.data = (v && sig == MFHI) ? hi_m : (v && sig == MFLO) ? lo_m : alu;
    e.cyc  = cyc;
    sb_q.push_back(e);
    if (!rst && v && is_mul_funct(sig) && !op_active) begin
      op_active = 1'b1;
      op_committed = 1'b0;
      op_edge = cyc + 1;
      op_prod = ref_product(sig, a, b);
    end
  endtask

  task automatic idle(input int n, input bit rst);
    logic [5:0] sig;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       sig = MFHI;
        1:       sig = MFLO;
        2:       sig = 6'($urandom);
        default: sig = MULT;
      endcase
      if (sig == MULTU) sig = 6'b100000;
      step(rst, 1'($urandom), sig, $urandom, $urandom, $urandom);
    end
  endtask

  task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    step(1'b0, 1'b1, sig, a, b, $urandom);
  endtask

  task automatic read(input logic [5:0] sig, input bit rst);
    step(rst, 1'b1, sig, $urandom, $urandom, $urandom);
  endtask

  // Scoreboard monitor: compare every presented cycle against the model.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks = checks + 1;
      if (bus.dataOut !== e.data) begin
        errors = errors + 1;
        $display("FAIL dataOut cyc=%0d actual=%h expected=%h", e.cyc, bus.dataOut, e.data);
      end
      checks = checks + 1;
      if (bus.busy !== e.busy) begin
        errors = errors + 1;
        $display("FAIL busy cyc=%0d actual=%b expected=%b", e.cyc, bus.busy, e.busy);
      end
      checks = checks + 1;
      if (bus.done !== e.done) begin
        errors = errors + 1;
        $display("FAIL done cyc=%0d actual=%b expected=%b", e.cyc, bus.done, e.done);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    op_active = 1'b0;
    op_committed = 1'b0;
    op_edge = 0;
    op_prod = 64'h0;
    hi_m = 32'h0;
    lo_m = 32'h0;
    reset = 1'b1;
    bus.valid = 1'b0;
    bus.Signal = 6'b000000;
    bus.dataA = 32'h0;
    bus.dataB = 32'h0;
    bus.aluOut = 32'h0;

    idle(3, 1'b1);
    read(MFLO, 1'b1);
    idle(2, 1'b0);

    // Small product, then read both halves after completion.
    issue(MULTU, 32'd3, 32'd5);
    idle(34, 1'b0);
    read(MFLO, 1'b0);
    read(MFHI, 1'b0);

    // Largest unsigned operands.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(34, 1'b0);
    read(MFHI, 1'b0);
    read(MFLO, 1'b0);

    // Old LO visible mid-multiply, new LO visible in the done cycle.
    issue(MULTU, 32'd3, 32'd5);
    idle(34, 1'b0);
    issue(MULTU, 32'd7, 32'd9);
    idle(8, 1'b0);
    read(MFLO, 1'b0);
    idle(23, 1'b0);
    read(MFLO, 1'b0);
    idle(3, 1'b0);

    // Second multiply while busy is dropped.
    issue(MULTU, 32'd2, 32'd2);
    idle(4, 1'b0);
    issue(MULTU, 32'd4, 32'd4);
    idle(32, 1'b0);
    read(MFLO, 1'b0);
    idle(5, 1'b0);

    // Reset mid-multiply abandons the operation.
    issue(MULTU, 32'd6, 32'd7);
    idle(10, 1'b0);
    read(MFLO, 1'b1);
    idle(1, 1'b1);
    read(MFLO, 1'b0);
    read(MFHI, 1'b0);
    idle(40, 1'b0);
    read(MFLO, 1'b0);

    // Funct 24: signed multiply when enabled, plain pass-through otherwise.
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    idle(34, 1'b0);
    read(MFHI, 1'b0);
    read(MFLO, 1'b0);

    // Random operations with random gaps, some shorter than the multiply.
    for (int k = 0; k < 16; k++) begin
      issue(($urandom_range(0, 1) == 0) ? MULTU : MULT, $urandom, $urandom);
      idle($urandom_range(0, 45), 1'b0);
      read(MFHI, 1'b0);
      read(MFLO, 1'b0);
    end
    idle(40, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_hilo_unit.md
MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; HI and LO are each WIDTH bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: valid  input  1  Signal/dataA/dataB qualify an instruction this cycle.
REQ-005 Port: Signal  input  6  R-type funct code, same encoding as the ALU's Signal.
REQ-006 Port: dataA  input  WIDTH  multiplicand (rs).
REQ-007 Port: dataB  input  WIDTH  multiplier (rt).
REQ-008 Port: aluOut  input  WIDTH  result from the 32-bit ALU, passed through when not MFHI/MFLO.
REQ-009 Port: dataOut  output  WIDTH  final execute-stage result.
REQ-010 Port: busy  output  1  multiply in progress.
REQ-011 Port: done  output  1  one-cycle pulse when HI/LO have just been written.

Function
REQ-012 Funct codes SHALL be MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010.
REQ-013 FSM states SHALL be IDLE, MUL, DONE.
REQ-014 In IDLE, valid && Signal==MULTU SHALL load the multiplicand (zero-extended to 2*WIDTH), the multiplier and a zeroed 2*WIDTH product, clear the counter, and enter MUL.
REQ-015 Each MUL cycle: if multiplier[0] is set, add the multiplicand to the product; shift the multiplicand left 1; shift the multiplier right 1; increment the counter.
REQ-016 After exactly WIDTH MUL cycles, the last MUL edge SHALL write HI=product[2W-1:W] and LO=product[W-1:0], then enter DONE.
REQ-017 DONE SHALL last exactly one cycle, assert done, then return to IDLE.
REQ-018 busy SHALL be 1 exactly while state==MUL; done SHALL be 1 exactly while state==DONE.
REQ-019 Latency: with acceptance at edge E0, HI/LO SHALL update at E32 and done SHALL be high between E32 and E33.
REQ-020 MULTU presented while not in IDLE (MUL or DONE) SHALL be ignored, with no queueing.
REQ-021 dataOut SHALL be combinational: HI when valid && Signal==MFHI, LO when valid && Signal==MFLO, otherwise aluOut.
REQ-022 MFHI/MFLO during MUL SHALL return the previous committed HI/LO, never partial products.
REQ-023 MFHI/MFLO in the same cycle as done SHALL return the newly written HI/LO.
REQ-024 Arithmetic SHALL be modulo 2^(2*WIDTH) with no overflow flag; the full product always fits.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, HI=0, LO=0, counter=0, product=0, busy=0 and done=0.
REQ-026 Reset mid-MUL SHALL abandon the operation, leaving HI/LO at 0.
REQ-027 dataOut SHALL remain combinational during reset, so aluOut passes through.

Configuration
REQ-028 With SIGNED_MULT_EN defined, funct MULT=6'b011000 SHALL be accepted like MULTU: it multiplies absolute values and two's-complement negates the 2*WIDTH product at commit when the operand signs differ, with identical latency.
REQ-029 Without SIGNED_MULT_EN, funct 6'b011000 SHALL be treated as a non-multiply: dataOut=aluOut, with no state change.

Structure
REQ-030 A shared package mul_hilo_pkg SHALL hold the funct constants (MULTU, MULT, MFHI, MFLO) and the state encoding typedef.
REQ-031 One sub-module, mul_shift_add, SHALL hold the product, multiplicand and multiplier registers and the adder; the FSM, counter, HI/LO and output mux SHALL stay in the top level.

Verification
REQ-032 MULTU 3×5 -> busy for 32 cycles; done pulses at cycle 33; then MFLO=0x0000000F and MFHI=0x00000000.
REQ-033 MULTU 0xFFFFFFFF×0xFFFFFFFF -> MFHI=0xFFFFFFFE and MFLO=0x00000001.
REQ-034 After LO=0x0F, start MULTU 7×9 and issue MFLO at cycle 10 -> 0x0F; issue MFLO in the done cycle -> 0x3F.
REQ-035 MULTU 2×2 followed by MULTU 4×4 at cycle 5 -> second ignored; LO=0x4 and only one done pulse.
REQ-036 Reset asserted at cycle 12 of MULTU 6×7 -> busy=0 and done=0 immediately; MFLO=0 and MFHI=0.
REQ-037 With SIGNED_MULT_EN, MULT 0xFFFFFFFE×3 -> HI=0xFFFFFFFF and LO=0xFFFFFFFA; without it, funct 24 -> dataOut=aluOut and busy stays 0.
